// File: rtl/dcmac_axis_pkt_cnt.sv
// dcmac_axis_pkt_cnt: six-port time-multiplexed 32-bit packet/byte accumulator with chainable overflow carries
module dcmac_axis_pkt_cnt #(
    parameter bit REGISTER_INPUT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       i_clear_counters,
    input  logic [2:0]       i_id_m1,
    input  logic [11:0]      i_sop,
    input  logic [11:0]      i_eop,
    input  logic [7:0]       i_size,
    output logic [5:0][31:0] o_pkt_cnt,
    output logic [5:0][31:0] o_byte_cnt,
    output logic [2:0]       o_carry_id_m1,
    output logic             o_pkt_cnt_carry,
    output logic             o_byte_cnt_carry
);
    logic [2:0]       id_in, id_q;
    logic [11:0]      eop_in;
    logic [7:0]       size_in;
    logic [5:0][31:0] pkt_q, byte_q;
    logic [31:0]      pkt_cur, byte_cur;
    logic [32:0]      pkt_sum, byte_sum;
    logic [3:0]       pop;
    logic             clr_sel, hit, pkt_carry, byte_carry;
    logic             sop_unused;

    assign sop_unused = ^i_sop;

    generate
        if (REGISTER_INPUT) begin : g_reg
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    id_in   <= '0;
                    eop_in  <= '0;
                    size_in <= '0;
                end else begin
                    id_in   <= i_id_m1;
                    eop_in  <= i_eop;
                    size_in <= i_size;
                end
            end
        end else begin : g_comb
            assign id_in   = i_id_m1;
            assign eop_in  = i_eop;
            assign size_in = i_size;
        end
    endgenerate

    always_comb begin
        pop = '0;
        for (int i = 0; i < 12; i++) pop = pop + 4'(eop_in[i]);
    end

    // IDs 6 and 7 select nothing, so the current value stays 0 and hit stays low
    always_comb begin
        pkt_cur  = '0;
        byte_cur = '0;
        clr_sel  = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (id_q == 3'(i)) begin
                pkt_cur  = pkt_q[i];
                byte_cur = byte_q[i];
                clr_sel  = i_clear_counters[i];
            end
        end
    end

    assign pkt_sum  = {1'b0, pkt_cur} + 33'(pop);
    assign byte_sum = {1'b0, byte_cur} + 33'(size_in);
    assign hit      = (id_q < 3'd6) && !clr_sel;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            id_q       <= '0;
            pkt_q      <= '0;
            byte_q     <= '0;
            pkt_carry  <= 1'b0;
            byte_carry <= 1'b0;
        end else begin
            id_q       <= id_in;
            pkt_carry  <= hit && pkt_sum[32];
            byte_carry <= hit && byte_sum[32];
            for (int i = 0; i < 6; i++) begin
                if (i_clear_counters[i]) begin
                    pkt_q[i]  <= '0;
                    byte_q[i] <= '0;
                end else if (id_q == 3'(i)) begin
                    pkt_q[i]  <= pkt_sum[31:0];
                    byte_q[i] <= byte_sum[31:0];
                end
            end
        end
    end

    assign o_pkt_cnt        = pkt_q;
    assign o_byte_cnt       = byte_q;
    assign o_carry_id_m1    = id_q;
    assign o_pkt_cnt_carry  = pkt_carry;
    assign o_byte_cnt_carry = byte_carry;
endmodule

// File: tb/tb_dcmac_axis_pkt_cnt.sv
// tb_dcmac_axis_pkt_cnt: scoreboard bench with a chained upper instance forming 64-bit counts
module tb_dcmac_axis_pkt_cnt;
    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [5:0]       i_clear_counters = '0;
    logic [2:0]       i_id_m1 = '0;
    logic [11:0]      i_sop = '0;
    logic [11:0]      i_eop = '0;
    logic [7:0]       i_size = '0;
    logic [5:0][31:0] o_pkt_cnt, o_byte_cnt, up_pkt_cnt, up_byte_cnt;
    logic [2:0]       o_carry_id_m1, up_carry_id;
    logic             o_pkt_cnt_carry, o_byte_cnt_carry, up_pkt_carry, up_byte_carry;

    always #5 clk = ~clk;

    dcmac_axis_pkt_cnt dut (
        .clk(clk), .rst(rst), .i_clear_counters(i_clear_counters), .i_id_m1(i_id_m1),
        .i_sop(i_sop), .i_eop(i_eop), .i_size(i_size), .o_pkt_cnt(o_pkt_cnt),
        .o_byte_cnt(o_byte_cnt), .o_carry_id_m1(o_carry_id_m1),
        .o_pkt_cnt_carry(o_pkt_cnt_carry), .o_byte_cnt_carry(o_byte_cnt_carry)
    );

    dcmac_axis_pkt_cnt upper (
        .clk(clk), .rst(rst), .i_clear_counters(6'd0), .i_id_m1(o_carry_id_m1),
        .i_sop(12'd0), .i_eop({11'd0, o_pkt_cnt_carry}), .i_size({7'd0, o_byte_cnt_carry}),
        .o_pkt_cnt(up_pkt_cnt), .o_byte_cnt(up_byte_cnt), .o_carry_id_m1(up_carry_id),
        .o_pkt_cnt_carry(up_pkt_carry), .o_byte_cnt_carry(up_byte_carry)
    );

    typedef struct packed {
        logic [5:0][31:0] pkt;
        logic [5:0][31:0] byt;
        logic [2:0]       cid;
        logic             pc;
        logic             bc;
    } exp_t;

    exp_t             q[$];
    logic [5:0][31:0] pkt_m = '0, byte_m = '0, up_pkt_m = '0, up_byte_m = '0;
    logic [2:0]       prev_id = '0;
    int               checks = 0, failures = 0;
    bit               pl_en = 0, pl_pkt = 0;
    int               pl_p = 0;
    logic [31:0]      pl_v = '0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Backdoor preload near the wrap point; 2^32 is out of reach by counting
    task automatic preload(input bit is_pkt, input int p, input logic [31:0] v);
        pl_en = 1; pl_pkt = is_pkt; pl_p = p; pl_v = v;
    endtask

    task automatic beat(input logic [2:0] nid, input logic [11:0] eop, input logic [7:0] sz,
                        input logic [5:0] clr);
        exp_t        e;
        logic [63:0] s;
        bit          pc = 0, bc = 0;
        @(negedge clk);
        if (pl_en) begin
            if (pl_pkt) begin dut.pkt_q[pl_p] = pl_v; pkt_m[pl_p] = pl_v; end
            else begin dut.byte_q[pl_p] = pl_v; byte_m[pl_p] = pl_v; end
            pl_en = 0;
        end
        i_id_m1 = nid; i_eop = eop; i_size = sz; i_clear_counters = clr;
        i_sop = 12'($urandom);
        if (prev_id < 6 && !clr[prev_id]) begin
            s = 64'(pkt_m[prev_id]) + 64'($countones(eop));
            pc = s >= 64'd4294967296;
            pkt_m[prev_id] = 32'(s % 64'd4294967296);
            s = 64'(byte_m[prev_id]) + 64'(sz);
            bc = s >= 64'd4294967296;
            byte_m[prev_id] = 32'(s % 64'd4294967296);
            if (pc) up_pkt_m[prev_id] = up_pkt_m[prev_id] + 1;
            if (bc) up_byte_m[prev_id] = up_byte_m[prev_id] + 1;
        end
        for (int i = 0; i < 6; i++) if (clr[i]) begin pkt_m[i] = 0; byte_m[i] = 0; end
        e.pkt = pkt_m; e.byt = byte_m; e.cid = nid; e.pc = pc; e.bc = bc;
        q.push_back(e);
        prev_id = nid;
    endtask

    task automatic reset_model();
        pkt_m = '0; byte_m = '0; up_pkt_m = '0; up_byte_m = '0; prev_id = '0;
        i_id_m1 = '0; i_eop = '0; i_size = '0; i_clear_counters = '0;
        q.delete();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pkt"}, 192'(o_pkt_cnt), '0);
        chk({tag, "_byte"}, 192'(o_byte_cnt), '0);
        chk({tag, "_cid_carries"}, 192'({o_carry_id_m1, o_pkt_cnt_carry, o_byte_cnt_carry}), '0);
        chk({tag, "_upper"}, 192'({up_pkt_cnt, up_byte_cnt}), '0);
    endtask

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (rst && q.size() != 0) begin
            e = q.pop_front();
            chk("pkt_cnt", 192'(o_pkt_cnt), 192'(e.pkt));
            chk("byte_cnt", 192'(o_byte_cnt), 192'(e.byt));
            chk("carry_id_m1", 192'(o_carry_id_m1), 192'(e.cid));
            chk("pkt_carry", 192'(o_pkt_cnt_carry), 192'(e.pc));
            chk("byte_carry", 192'(o_byte_cnt_carry), 192'(e.bc));
        end
    end

    initial begin
        #1;
        chk_zero("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        beat(2, 12'h000, 8'd0, 6'd0);
        beat(3, 12'h801, 8'd100, 6'd0);
        repeat (4) beat(3, 12'h010, 8'd192, 6'd0);
        beat(1, 12'h000, 8'd0, 6'd0);
        preload(0, 1, 32'hFFFF_FFA0);
        beat(5, 12'h001, 8'd192, 6'd0);
        preload(1, 5, 32'hFFFF_FFFE);
        beat(2, 12'hFFF, 8'd20, 6'd0);
        beat(2, 12'h003, 8'd50, 6'd0);
        beat(7, 12'h00F, 8'd60, 6'b000100);
        beat(6, 12'h000, 8'd0, 6'd0);
        beat(7, 12'hFFF, 8'd192, 6'd0);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(15, 0) == 0)
                preload($urandom_range(1, 0) == 1, $urandom_range(5, 0), 32'hFFFF_FF00 | 32'($urandom_range(255, 0)));
            beat(3'($urandom_range(7, 0)),
                 ($urandom_range(3, 0) == 0) ? 12'($urandom) : 12'($urandom) & 12'h041,
                 8'($urandom_range(192, 0)),
                 ($urandom_range(15, 0) == 0) ? 6'($urandom) & 6'($urandom) : 6'd0);
        end
        repeat (4) beat(7, 12'h000, 8'd0, 6'd0);
        @(posedge clk);
        #2;
        chk("upper_pkt", 192'(up_pkt_cnt), 192'(up_pkt_m));
        chk("upper_byte", 192'(up_byte_cnt), 192'(up_byte_m));
        chk("queue_drain", 192'(q.size()), 192'(0));
        beat(6, 12'h000, 8'd0, 6'd0);
        beat(0, 12'hFFF, 8'd192, 6'd0);
        beat(4, 12'h801, 8'd77, 6'd0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_zero("async_reset");
        reset_model();
        @(negedge clk);
        rst = 1'b1;
        beat(4, 12'h000, 8'd0, 6'd0);
        beat(7, 12'h101, 8'd33, 6'd0);
        beat(7, 12'h000, 8'd0, 6'd0);
        @(posedge clk);
        #2;
        chk("final_drain", 192'(q.size()), 192'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
